// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with per-client packet lock and a busy-timeout for an unresponsive transmitter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            tx_busy,
  output logic [DATA_WIDTH-1:0]           tx_data,
  output logic                            tx_data_valid,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(NUM_REQ)-1:0]      owner,
  output logic                            active,
  output logic                            timeout_err
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;
  localparam logic [OW-1:0] OWNER_RST   = OW'(NUM_REQ - 1);
  localparam logic [CW:0]   TIMEOUT_LIM = (CW+1)'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    valid_q, valid_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic                    active_q, active_d;
  logic                    timeout_q, timeout_d;
  logic                    lock_valid_q, lock_valid_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [OW-1:0]           rr_sel;
  logic                    rr_hit;
  logic [OW-1:0]           cand;
  logic                    lock_hold;
  logic [OW-1:0]           sel;
  logic                    elig;

  // Round-robin search from owner+1; iterating downward leaves the nearest hit in rr_sel.
  always_comb begin
    rr_sel = owner_q;
    rr_hit = 1'b0;
    cand   = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = OW'((int'(owner_q) + i) % int'(NUM_REQ));
      if (req[cand]) begin
        rr_sel = cand;
        rr_hit = 1'b1;
      end
    end
  end

  // A held lock bypasses the search; other clients wait even if the owner is not requesting.
  always_comb begin
    lock_hold = lock_valid_q && req_lock[owner_q];
    sel       = lock_hold ? owner_q : rr_sel;
    elig      = lock_hold ? req[owner_q] : rr_hit;
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    valid_d      = 1'b0;
    grant_d      = '0;
    owner_d      = owner_q;
    lock_valid_d = lock_valid_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!req_lock[owner_q]) begin
          lock_valid_d = 1'b0;
        end
        if (!tx_busy && elig) begin
          tx_data_d    = req_data[sel*DATA_WIDTH +: DATA_WIDTH];
          valid_d      = 1'b1;
          grant_d      = NUM_REQ'(1) << sel;
          owner_d      = sel;
          lock_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Busy rising on the timeout cycle takes priority over the error.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (({1'b0, cnt_q} + (CW+1)'(1)) >= TIMEOUT_LIM) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tx_data_q    <= '0;
      valid_q      <= 1'b0;
      grant_q      <= '0;
      owner_q      <= OWNER_RST;
      active_q     <= 1'b0;
      timeout_q    <= 1'b0;
      lock_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      valid_q      <= valid_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      active_q     <= active_d;
      timeout_q    <= timeout_d;
      lock_valid_q <= lock_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = valid_q;
  assign grant         = grant_q;
  assign owner         = owner_q;
  assign active        = active_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_lock;
  logic [31:0] req_data;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        active;
  logic        timeout_err;

  logic        model_en;
  logic        man_busy;
  logic        auto_busy;
  logic        armed;
  int          t;
  int          busy_dly;
  int          busy_len;
  int          cyc;
  int          checks;
  int          failures;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .BUSY_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .req_lock(req_lock),
    .req_data(req_data),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .grant(grant),
    .owner(owner),
    .active(active),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign tx_busy = model_en ? auto_busy : man_busy;

  // Transmitter model: busy rises busy_dly cycles after a valid, stays high busy_len cycles.
  always @(negedge clock) begin
    if (!model_en || reset) begin
      armed     <= 1'b0;
      t         <= 0;
      auto_busy <= 1'b0;
    end else if (armed) begin
      t <= t + 1;
      if (t + 1 == busy_dly) auto_busy <= 1'b1;
      if (t + 1 == busy_dly + busy_len) begin
        auto_busy <= 1'b0;
        armed     <= 1'b0;
      end
    end else if (tx_data_valid) begin
      armed <= 1'b1;
      t     <= 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_valid(input int max, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (tx_data_valid === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (active === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({tx_data, tx_data_valid, grant, owner, active, timeout_err} !== {8'h00, 1'b0, 4'h0, 2'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got data=%h v=%b g=%b own=%0d act=%b te=%b want 00 0 0000 3 0 0",
               tx_data, tx_data_valid, grant, owner, active, timeout_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int at1, at2;
    model_en = 1'b1;
    busy_dly = 2;
    busy_len = 20;
    @(negedge clock);
    req = 4'b0010;
    wait_valid(1, ok, at1);
    checks++;
    if (!ok || {grant, tx_data, owner, active} !== {4'b0010, 8'hA5, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL single_grant: ok=%b g=%b data=%h own=%0d act=%b want 1 0010 a5 1 1",
               ok, grant, tx_data, owner, active);
    end
    wait_valid(40, ok, at2);
    checks++;
    if (!ok || (at2 - at1) != 24) begin
      failures++;
      $display("FAIL single_spacing: ok=%b gap=%0d want gap 24", ok, at2 - at1);
    end
    req = 4'b0000;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_idle: active=%b want 0", active);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int at;
    logic [7:0] exp_byte [4];
    logic [3:0] exp_g;
    exp_byte[0] = 8'hC3;
    exp_byte[1] = 8'hA5;
    exp_byte[2] = 8'h5A;
    exp_byte[3] = 8'h3C;
    apply_reset();
    busy_len = 3;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'(1 << (k % 4));
      wait_valid(30, ok, at);
      if (k == 7) req = 4'b0000;
      checks++;
      if (!ok || grant !== exp_g || !$onehot(grant) || tx_data !== exp_byte[k % 4]) begin
        failures++;
        $display("FAIL fair_grant%0d: ok=%b g=%b data=%h want g=%b data=%h",
                 k, ok, grant, tx_data, exp_g, exp_byte[k % 4]);
      end
      @(negedge clock);
      checks++;
      if (grant !== 4'b0000 || tx_data_valid !== 1'b0) begin
        failures++;
        $display("FAIL fair_pulse%0d: g=%b v=%b want 0000 0", k, grant, tx_data_valid);
      end
    end
    wait_idle(40, ok);
  endtask

  task automatic test_lock();
    bit ok;
    int at;
    req_lock = 4'b0100;
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_valid(30, ok, at);
      if (k == 0) req = 4'b1101;
      if (k == 2) req = 4'b1001;
      checks++;
      if (!ok || grant !== 4'b0100) begin
        failures++;
        $display("FAIL lock_grant%0d: ok=%b g=%b want 0100", k, ok, grant);
      end
    end
    wait_valid(20, ok, at);
    checks++;
    if (ok) begin
      failures++;
      $display("FAIL lock_hold: got grant g=%b want none while lock held", grant);
    end
    req_lock = 4'b0000;
    wait_valid(30, ok, at);
    req = 4'b0001;
    checks++;
    if (!ok || grant !== 4'b1000) begin
      failures++;
      $display("FAIL lock_release_a: ok=%b g=%b want 1000", ok, grant);
    end
    wait_valid(30, ok, at);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0001) begin
      failures++;
      $display("FAIL lock_release_b: ok=%b g=%b want 0001", ok, grant);
    end
    wait_idle(40, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int at, first, pulses, extra;
    logic act14, act15;
    model_en = 1'b0;
    man_busy = 1'b0;
    first = 0;
    pulses = 0;
    extra = 0;
    act14 = 1'b0;
    act15 = 1'b1;
    @(negedge clock);
    req = 4'b0001;
    wait_valid(3, ok, at);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0001) begin
      failures++;
      $display("FAIL to_issue: ok=%b g=%b want 0001", ok, grant);
    end
    for (int i = 1; i <= 17; i++) begin
      @(negedge clock);
      if (timeout_err === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (tx_data_valid !== 1'b0) extra++;
      if (i == 14) act14 = active;
      if (i == 15) act15 = active;
    end
    checks++;
    if (first != 15 || pulses != 1) begin
      failures++;
      $display("FAIL to_pulse: first=%0d pulses=%0d want first=15 pulses=1", first, pulses);
    end
    checks++;
    if (act14 !== 1'b1 || act15 !== 1'b0 || extra != 0) begin
      failures++;
      $display("FAIL to_state: act14=%b act15=%b extra=%0d want 1 0 0", act14, act15, extra);
    end
  endtask

  task automatic test_busy_collision();
    bit ok;
    int at, pulses;
    pulses = 0;
    man_busy = 1'b1;
    @(negedge clock);
    req = 4'b0001;
    wait_valid(6, ok, at);
    checks++;
    if (ok) begin
      failures++;
      $display("FAIL col_blocked: got grant g=%b want none while busy", grant);
    end
    man_busy = 1'b0;
    wait_valid(1, ok, at);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0001) begin
      failures++;
      $display("FAIL col_issue: ok=%b g=%b want 0001", ok, grant);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (timeout_err === 1'b1) pulses++;
      if (i == 14) man_busy = 1'b1;
    end
    checks++;
    if (pulses != 0 || active !== 1'b1) begin
      failures++;
      $display("FAIL col_race: pulses=%0d act=%b want 0 1", pulses, active);
    end
    man_busy = 1'b0;
    wait_idle(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL col_done: active=%b want 0", active);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int at;
    model_en = 1'b1;
    busy_dly = 2;
    busy_len = 20;
    @(negedge clock);
    req = 4'b0010;
    wait_valid(3, ok, at);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0010) begin
      failures++;
      $display("FAIL mid_issue: ok=%b g=%b want 0010", ok, grant);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (active !== 1'b1 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL mid_frame: act=%b data=%h want 1 a5", active, tx_data);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({tx_data, tx_data_valid, grant, owner, active, timeout_err} !== {8'h00, 1'b0, 4'h0, 2'd3, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got data=%h v=%b g=%b own=%0d act=%b te=%b want 00 0 0000 3 0 0",
               tx_data, tx_data_valid, grant, owner, active, timeout_err);
    end
    @(negedge clock);
    reset = 1'b0;
    req = 4'b1001;
    wait_valid(2, ok, at);
    req = 4'b0000;
    checks++;
    if (!ok || grant !== 4'b0001 || tx_data !== 8'hC3 || owner !== 2'd0) begin
      failures++;
      $display("FAIL mid_after: ok=%b g=%b data=%h own=%0d want 0001 c3 0", ok, grant, tx_data, owner);
    end
    wait_idle(40, ok);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    req_lock = 4'b0000;
    req_data = {8'h3C, 8'h5A, 8'hA5, 8'hC3};
    model_en = 1'b0;
    man_busy = 1'b0;
    busy_dly = 2;
    busy_len = 20;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_busy_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
